// File: rtl/alu_serial.sv
// alu_serial: bit-serial WIDTH-bit NOR/XOR/ADD/SUB ALU, LSB first, one bit per cycle.
// Define ALU_SERIAL_FLAGS_EN to build the zero/ovf flag logic; otherwise both flags are tied 0.
module alu_serial #(
   parameter int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [1:0]       op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero,
   output logic             ovf
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] a_sh, b_sh, acc;
   logic [1:0] op_r;
   logic [CNT_W-1:0] cnt;
   logic c, last, arith, bi, ri, co;
   assign last = cnt == CNT_W'(WIDTH - 1);
   assign arith = op_r[1];
   assign bi = b_sh[0] ^ (op_r == 2'b11);
   assign co = (a_sh[0] & bi) | (a_sh[0] & c) | (bi & c);
   assign busy = state == RUN;
   assign done = state == DONE;
   always_comb begin
      ri = 1'b0;
      ri = op_r == 2'b00 ? ~(a_sh[0] | b_sh[0]) :
           op_r == 2'b01 ? a_sh[0] ^ b_sh[0] : a_sh[0] ^ bi ^ c;
   end
   always_comb begin
      state_nx = state;
      state_nx = state == IDLE ? (start ? RUN : IDLE) :
                 state == RUN  ? (last ? DONE : RUN) : IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh <= '0;
         b_sh <= '0;
         acc <= '0;
         op_r <= '0;
         cnt <= '0;
         c <= 1'b0;
         result <= '0;
         cout <= 1'b0;
      end else if (state == IDLE && start) begin
         a_sh <= a;
         b_sh <= b;
         op_r <= op;
         cnt <= '0;
         c <= op == 2'b10 ? cin : op == 2'b11;
      end else if (state == RUN) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         c <= co;
         cnt <= cnt + CNT_W'(1);
         acc <= {ri, acc[WIDTH-1:1]};
         if (last) begin
            result <= {ri, acc[WIDTH-1:1]};
            cout <= arith & co;
         end
      end
   end
`ifdef ALU_SERIAL_FLAGS_EN
   logic or_acc, zero_r, ovf_r;
   assign zero = zero_r;
   assign ovf = ovf_r;
   // c at the last bit is the carry into the MSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         or_acc <= 1'b0;
         zero_r <= 1'b0;
         ovf_r <= 1'b0;
      end else if (state == IDLE && start) begin
         or_acc <= 1'b0;
      end else if (state == RUN) begin
         or_acc <= or_acc | ri;
         if (last) begin
            zero_r <= ~(or_acc | ri);
            ovf_r <= arith & (c ^ co);
         end
      end
   end
`else
   assign zero = 1'b0;
   assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: directed-vector self-checking bench for alu_serial (WIDTH=8).
module tb_alu_serial;
   localparam int W = 8;
`ifdef ALU_SERIAL_FLAGS_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic cin = 1'b0;
   logic [1:0] op = '0;
   logic busy, done, cout, zero, ovf;
   logic [W-1:0] result;
   logic [W-1:0] prev = '0;
   int total = 0, bad = 0;

   alu_serial #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .op(op),
      .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic ci, input logic [W-1:0] er,
                         input logic ec, input logic ez, input logic ev);
      @(negedge clk);
      op = o; a = x; b = y; cin = ci; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      a = ~x; b = ~y; cin = ~ci; op = ~o;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         check({tag, "_busy"}, {busy, done}, 2'b10);
         if (i == 0) check({tag, "_hold"}, result, prev);
      end
      @(negedge clk);
      check({tag, "_done"}, {busy, done}, 2'b01);
      check({tag, "_res"}, result, er);
      check({tag, "_cout"}, cout, ec);
      check({tag, "_zero"}, zero, ez & FL);
      check({tag, "_ovf"}, ovf, ev & FL);
      @(negedge clk);
      check({tag, "_idle"}, {busy, done}, 2'b00);
      check({tag, "_keep"}, result, er);
      prev = er;
   endtask

   initial begin
      int dcnt, both;
      #12;
      check("rst_out", {busy, done, result, cout, zero, ovf}, '0);
      rst_n = 1'b1;
      run_op("add_ff", 2'b10, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      run_op("sub_80", 2'b11, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b1);
      run_op("sub_01", 2'b11, 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
      run_op("nor", 2'b00, 8'hF0, 8'h0C, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
      run_op("xor", 2'b01, 8'hA5, 8'hFF, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      run_op("add_c", 2'b10, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1);
      // start held through RUN and into DONE; operands changed mid-run
      @(negedge clk);
      op = 2'b10; a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
      dcnt = 0; both = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (i == 3) begin a = 8'hFF; b = 8'hFF; end
         if (busy && done) both++;
         if (done) begin
            dcnt++;
            check("held_res", result, 8'h46);
            @(posedge clk);
            #1 start = 1'b0;
         end
      end
      check("held_pulses", dcnt, 1);
      check("held_overlap", both, 0);
      prev = 8'h46;
      // reset in the 4th RUN cycle
      @(negedge clk);
      op = 2'b10; a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid_rst", {busy, done, result, cout, zero, ovf}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done || busy) dcnt++;
      end
      check("mid_quiet", dcnt, 0);
      prev = 8'h00;
      run_op("add_after", 2'b10, 8'h03, 8'h04, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Parametrised successor of the single-bit ALU cell: a bit-serial WIDTH-bit ALU.
- Reuses one 1-bit datapath (NOR / XOR / full-add with operand invert) over WIDTH cycles, LSB first.
- A registered carry flip-flop links the bit slices.
- Operands and opcode are captured on a start/done handshake.
- Sits between the register file and the writeback mux in the small-core datapath, where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-index counter width; derived, not overridden.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request; sampled only in IDLE.
- a, input, WIDTH, operand A; captured when start is accepted.
- b, input, WIDTH, operand B; captured when start is accepted.
- cin, input, 1, carry in for ADD; captured with the operands; ignored for other ops.
- op, input, 2, operation: 00 NOR, 01 XOR, 10 ADD, 11 SUB (A-B); captured with the operands.
- busy, output, 1, high while a serial operation is in progress.
- done, output, 1, one-cycle pulse when result is valid.
- result, output, WIDTH, operation result; holds until next completion.
- cout, output, 1, final carry out; 0 for NOR/XOR.
- zero, output, 1, result==0 flag (see Optional Feature).
- ovf, output, 1, signed overflow flag (see Optional Feature).

Behaviour:
- Reset: asynchronous, active-low. state=IDLE; busy=0, done=0, result=0, cout=0, zero=0, ovf=0; counter, carry FF and operand registers cleared.

State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 latches a, b and op into shift registers.
  - Carry FF loads: cin for ADD; 1 for SUB; 0 for NOR/XOR.
  - Counter loads 0; go to RUN.
- RUN, each cycle processes bit i = counter:
  - NOR: r_i = ~(a_i | b_i).
  - XOR: r_i = a_i ^ b_i.
  - ADD: r_i = a_i ^ b_i ^ c; c <= majority(a_i, b_i, c).
  - SUB: identical to ADD with b_i inverted. cout=1 means no borrow, i.e. A>=B unsigned.
  - r_i is shifted into result MSB-side; operand registers shift right; counter increments.
  - When counter==WIDTH-1, the bit is processed and the state goes to DONE at that edge.
- DONE: done=1 for exactly one cycle; result and cout (and flags) are valid. Return to IDLE unconditionally.

Timing:
- start sampled high at edge k -> busy=1 for cycles k+1..k+WIDTH -> done=1 in cycle k+WIDTH+1.
- Throughput: one op per WIDTH+2 cycles.
- result updates only on completion. Intermediate shift contents are held in an internal register, so result shows the previous value while busy.

Boundary rules:
- start while RUN or DONE: ignored, no queuing; inputs may change freely after capture.
- busy and done are never high together.
- Counter wraps only through reload in IDLE; no modulo-WIDTH aliasing for non-power-of-2 WIDTH (e.g. WIDTH=5 runs exactly 5 RUN cycles).
- cout for NOR/XOR is forced 0.
- rst_n low mid-RUN: immediate return to IDLE with all outputs cleared; the partial result is discarded and no done pulse occurs.

Optional Feature:
- Macro: ALU_SERIAL_FLAGS_EN.
- Defined:
  - zero = (final result == 0), computed serially by an OR-accumulator over r_i.
  - ovf = carry into MSB XOR carry out, for ADD/SUB; 0 for NOR/XOR.
  - Both update together with result on completion and hold until the next completion.
- Not defined: zero and ovf are tied 0; the accumulator and MSB-carry logic are not instantiated. Ports remain present.

Test Plan (WIDTH=8, ALU_SERIAL_FLAGS_EN defined unless noted):
- ADD a=0xFF, b=0x01, cin=0, start for 1 cycle -> busy 8 cycles; done in cycle 9 after start; result=0x00, cout=1, zero=1, ovf=0.
- SUB a=0x80, b=0x01 -> result=0x7F, cout=1, ovf=1, zero=0. Then SUB a=0x01, b=0x02 -> result=0xFF, cout=0, ovf=0.
- NOR a=0xF0, b=0x0C -> result=0x03, cout=0. XOR a=0xA5, b=0xFF -> result=0x5A, cout=0, ovf=0.
- Start held high through RUN, and start pulsed in DONE -> exactly one done pulse per IDLE acceptance. Changing a/b during busy does not alter result.
- ADD a=0x10, b=0x20; drop rst_n at cycle 4 of RUN -> all outputs 0 immediately; no done. A new ADD a=0x03, b=0x04, cin=1 -> result=0x08.
- Macro undefined, ADD 0xFF+0x01 -> result=0x00, cout=1, zero=0, ovf=0.
